truth_table_sweeper: RTL and testbench

- Sequencer that exhaustively drives every input combination into a combinational N_IN-input logic gate or circuit-under-test.
- After a programmable settle time, it samples the gate output twice and assembles the measured truth table in the team's hex-ID bit order.
- Compares the measured table against an expected ID and flags mismatches and unstable outputs.
- Sits between a test or characterisation host and one truth-table gate instance.

---
 rtl/truth_table_sweeper.sv | 116 +++++++++++
 tb/tb_truth_table_sweeper.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a combinational gate through every input
// combination, samples its output twice per vector after a settle delay,
// builds the measured truth table and compares it against an expected ID.
module truth_table_sweeper #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 table_valid,
  output logic                 match,
  output logic                 glitch
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    CONFIRM,
    DONE
  } state_t;

  state_t           state;
  logic [N_IN-1:0]  index;
  logic [CNT_W-1:0] counter;
  logic             sample_a;

  // Sweep sequencer: drives vectors, waits out the settle time, double-samples
  // the gate output and assembles the table bit addressed by the vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dut_in      <= '0;
      done        <= 1'b0;
      table_out   <= '0;
      table_valid <= 1'b0;
      glitch      <= 1'b0;
      index       <= '0;
      counter     <= '0;
      sample_a    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Partial table is kept for inspection but never marked valid.
        state       <= IDLE;
        dut_in      <= '0;
        table_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state       <= DRIVE;
              dut_in      <= '0;
              index       <= '0;
              table_out   <= '0;
              table_valid <= 1'b0;
              glitch      <= 1'b0;
            end
          end
          DRIVE: begin
            counter <= CNT_W'(SETTLE_CYCLES);
            state   <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
          end
          SETTLE: begin
            counter <= counter - 1'b1;
            if (counter == CNT_W'(1)) begin
              state <= SAMPLE;
            end
          end
          SAMPLE: begin
            sample_a <= dut_out;
            state    <= CONFIRM;
          end
          CONFIRM: begin
            table_out[index] <= dut_out;
            if (sample_a != dut_out) begin
              glitch <= 1'b1;
            end
            if (index == '1) begin
              // done/table_valid are registered here so they are visible
              // during the single DONE cycle.
              state       <= DONE;
              done        <= 1'b1;
              table_valid <= 1'b1;
              dut_in      <= '0;
            end else begin
              index  <= index + 1'b1;
              dut_in <= index + 1'b1;
              state  <= DRIVE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy  = (state != IDLE);
  assign match = table_valid && (table_out == expected);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: a gate described by its truth table is
// swept by a default-configured instance and a zero-settle instance; results
// are checked against values computed directly from the gate table.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst;

  // Instance A: default parameters (settle 4, 7 cycles per vector).
  logic       start_a, abort_a, dut_out_a, busy_a, done_a, valid_a, match_a, glitch_a;
  logic [7:0] exp_a, table_a, gate_a;
  logic [2:0] dut_in_a;
  logic       flip_a;

  // Instance B: zero settle (3 cycles per vector).
  logic       start_b, abort_b, dut_out_b, busy_b, done_b, valid_b, match_b, glitch_b;
  logic [7:0] exp_b, table_b, gate_b;
  logic [2:0] dut_in_b;

  int errors = 0;
  int checks = 0;

  assign dut_out_a = gate_a[dut_in_a] ^ flip_a;
  assign dut_out_b = gate_b[dut_in_b];

  truth_table_sweeper u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .expected(exp_a),
    .dut_out(dut_out_a), .dut_in(dut_in_a), .busy(busy_a), .done(done_a),
    .table_out(table_a), .table_valid(valid_a), .match(match_a), .glitch(glitch_a)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(0), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .expected(exp_b),
    .dut_out(dut_out_b), .dut_in(dut_in_b), .busy(busy_b), .done(done_b),
    .table_out(table_b), .table_valid(valid_b), .match(match_b), .glitch(glitch_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full sweep on instance A. flip_at >= 0 inverts the gate output during the
  // cycle ending at edge flip_at+1 (counted from the accepting edge).
  task automatic run_a(input logic [7:0] tt, input logic [7:0] exp, input int flip_at,
                       input logic exp_glitch, input logic [7:0] exp_table, input string tag);
    int n;
    bit seq_ok;
    gate_a = tt;
    exp_a  = exp;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    seq_ok = (dut_in_a === 3'd0) && (busy_a === 1'b1);
    while (done_a !== 1'b1 && n < 200) begin
      flip_a = (flip_at >= 0 && n == flip_at);
      @(posedge clk); #1;
      n++;
      if (done_a !== 1'b1 && (dut_in_a !== 3'(n / 7) || busy_a !== 1'b1)) seq_ok = 1'b0;
    end
    flip_a = 1'b0;
    chk({tag, " done_cycle"}, n, 56);
    chk({tag, " dut_in_seq"}, 32'(seq_ok), 1);
    chk({tag, " table"}, table_a, exp_table);
    chk({tag, " valid"}, valid_a, 1'b1);
    chk({tag, " match"}, match_a, 32'(exp_table == exp));
    chk({tag, " glitch"}, glitch_a, exp_glitch);
    chk({tag, " dut_in_done"}, dut_in_a, 3'd0);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, done_a, 1'b0);
    chk({tag, " busy_after"}, busy_a, 1'b0);
    chk({tag, " valid_held"}, valid_a, 1'b1);
  endtask

  // Sweep on instance B with a spurious start pulse mid-sweep.
  task automatic run_b(input logic [7:0] tt, input logic [7:0] exp, input string tag);
    int n;
    bit seq_ok;
    gate_b = tt;
    exp_b  = exp;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    seq_ok = (dut_in_b === 3'd0);
    while (done_b !== 1'b1 && n < 200) begin
      start_b = (n == 5);
      @(posedge clk); #1;
      n++;
      if (done_b !== 1'b1 && dut_in_b !== 3'(n / 3)) seq_ok = 1'b0;
    end
    start_b = 1'b0;
    chk({tag, " done_cycle"}, n, 24);
    chk({tag, " dut_in_seq"}, 32'(seq_ok), 1);
    chk({tag, " table"}, table_b, tt);
    chk({tag, " valid"}, valid_b, 1'b1);
    chk({tag, " match"}, match_b, 32'(tt == exp));
    chk({tag, " glitch"}, glitch_b, 1'b0);
    @(posedge clk); #1;
    chk({tag, " busy_after"}, busy_b, 1'b0);
  endtask

  initial begin
    logic [7:0] tt;
    logic [7:0] ex;
    int n;
    bit seen;
    rst = 1'b1;
    start_a = 0; abort_a = 0; exp_a = '0; gate_a = '0; flip_a = 0;
    start_b = 0; abort_b = 0; exp_b = '0; gate_b = '0;
    #2;
    chk("reset dut_in", dut_in_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset table", table_a, 0);
    chk("reset valid", valid_a, 0);
    chk("reset glitch", glitch_a, 0);
    chk("reset match", match_a, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed gates.
    run_a(8'h00, 8'h00, -1, 1'b0, 8'h00, "const0");
    run_a(8'h80, 8'h00, -1, 1'b0, 8'h80, "and3_exp00");
    run_a(8'h80, 8'h80, -1, 1'b0, 8'h80, "and3_exp80");

    // Zero-settle instance, out = in3 (LSB of dut_in), with ignored start.
    run_b(8'hAA, 8'hAA, "in3_s0");
    tt = 8'($urandom);
    run_b(tt, 8'($urandom), "rand_s0");

    // Sample A of vector 5 sees 0, sample B sees 1.
    run_a(8'hFF, 8'hFF, 40, 1'b1, 8'hFF, "glitch_v5");

    // start together with abort in IDLE is refused.
    @(posedge clk); #1 begin start_a = 1'b1; abort_a = 1'b1; end
    @(posedge clk); #1 begin start_a = 1'b0; abort_a = 1'b0; end
    chk("start_abort busy", busy_a, 0);
    chk("start_abort valid_kept", valid_a, 1);
    chk("start_abort glitch_kept", glitch_a, 1);

    // Abort during SETTLE of vector 3.
    tt = 8'($urandom);
    gate_a = tt;
    exp_a = tt;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (23) @(posedge clk);
    #1 abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    chk("abort busy", busy_a, 0);
    chk("abort dut_in", dut_in_a, 0);
    chk("abort valid", valid_a, 0);
    chk("abort match", match_a, 0);
    chk("abort partial_table", table_a, {5'b0, tt[2:0]});
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1 || busy_a !== 1'b0) seen = 1;
    end
    chk("abort no_done", 32'(seen), 0);

    // Asynchronous reset mid-sweep.
    gate_a = 8'hFF;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("pre_rst table_nonzero", 32'(table_a != 8'h00), 1);
    rst = 1'b1;
    #1;
    chk("rst dut_in", dut_in_a, 0);
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst table", table_a, 0);
    chk("rst valid", valid_a, 0);
    chk("rst glitch", glitch_a, 0);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy_a !== 1'b0) n++;
    end
    chk("rst stays_idle", n, 0);

    // Randomised gates after reset.
    for (int k = 0; k < 4; k++) begin
      tt = 8'($urandom);
      ex = ($urandom_range(0, 1) == 1) ? tt : 8'($urandom);
      run_a(tt, ex, -1, 1'b0, tt, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
